// File: rtl/mul_hilo_ctrl.sv
// HI/LO register controller for a fixed-latency external multiplier.
// Accepts MULT/MTHI/MTLO/NOP requests and captures the product after MUL_LAT cycles.
module mul_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    input  logic        mul_ovf,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MTHI = 2'b01;
    localparam logic [1:0] OP_MTLO = 2'b10;
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state;
    logic [3:0] cnt;

    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_MULT: begin
                                mul_a <= req_a;
                                mul_b <= req_b;
                                busy  <= 1'b1;
                                state <= S_ISSUE;
                            end
                            OP_MTHI: hi <= req_a;
                            OP_MTLO: lo <= req_a;
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done is raised on entry so it is high for the whole CAPTURE cycle
                    if (cnt == 4'd0) begin
                        state <= S_CAPTURE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    hi    <= mul_c[63:32];
                    lo    <= mul_c[31:0];
                    ovf   <= mul_ovf;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
